matrix_op_unit: RTL

- Datapath stage directly downstream of the execution engine. Accepts one decoded instruction at a time: op, dest, src.
- Holds an 8-entry file of 4x4 matrices with 16-bit elements and performs LOAD/ADD/SUB/SCAL MUL/MATR MUL/TRANSPOSE sequentially, one element (or one MAC) per cycle.
- Signals completion back to the engine so the engine can advance its program counter.

---
 rtl/matrix_pkg.sv | 32 +++
 rtl/matrix_regfile.sv | 49 ++++
 rtl/matrix_op_unit.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix unit and the execution engine:
// opcodes, FSM encoding, default sizes and the row/column index helper.
package matrix_pkg;

  localparam int DATA_W  = 16;
  localparam int DIM     = 4;
  localparam int NUM_MAT = 8;
  localparam int NUM_EL  = DIM * DIM;
  localparam int IDX_W   = $clog2(NUM_EL);
  localparam int ROW_W   = $clog2(DIM);
  localparam int MAT_W   = $clog2(NUM_MAT);

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_SCAL  = 3'd4;
  localparam logic [2:0] OP_MMUL  = 3'd5;
  localparam logic [2:0] OP_XPOSE = 3'd6;
  localparam logic [2:0] OP_STOP  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_ELEM, ST_MMUL, ST_XPOSE, ST_COMMIT, ST_HALT
  } state_t;

  // Row-major element index; DIM is a power of two, so this is a concatenation.
  function automatic logic [IDX_W-1:0] idx(input logic [ROW_W-1:0] row,
                                           input logic [ROW_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/matrix_regfile.sv
// Eight 4x4 matrix registers: two operand read ports, a debug read port,
// a single-element write port and a whole-matrix commit port.
module matrix_regfile
  import matrix_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [MAT_W-1:0]         i_a_mat,
  input  logic [IDX_W-1:0]         i_a_idx,
  output logic [DATA_W-1:0]        o_a_data,
  input  logic [MAT_W-1:0]         i_b_mat,
  input  logic [IDX_W-1:0]         i_b_idx,
  output logic [DATA_W-1:0]        o_b_data,
  input  logic [MAT_W-1:0]         i_rd_mat,
  input  logic [IDX_W-1:0]         i_rd_idx,
  output logic [DATA_W-1:0]        o_rd_data,
  input  logic                     i_we,
  input  logic [MAT_W-1:0]         i_w_mat,
  input  logic [IDX_W-1:0]         i_w_idx,
  input  logic [DATA_W-1:0]        i_w_data,
  input  logic                     i_commit,
  input  logic [MAT_W-1:0]         i_c_mat,
  input  logic [NUM_EL*DATA_W-1:0] i_c_data
);

  logic [DATA_W-1:0] r_mem [NUM_MAT][NUM_EL];

  // NOTE: this storage is reset on purpose because the engine relies on every
  // matrix reading as zero after reset; that forces flops rather than a RAM macro.
  // NOTE: sequential state uses non-blocking assignments only, so every reader
  // sees the pre-edge value regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int m = 0; m < NUM_MAT; m++)
        for (int e = 0; e < NUM_EL; e++)
          r_mem[m][e] <= '0;
    end else if (i_commit) begin
      for (int e = 0; e < NUM_EL; e++)
        r_mem[i_c_mat][e] <= i_c_data[e*DATA_W +: DATA_W];
    end else if (i_we) begin
      r_mem[i_w_mat][i_w_idx] <= i_w_data;
    end
  end

  assign o_a_data  = r_mem[i_a_mat][i_a_idx];
  assign o_b_data  = r_mem[i_b_mat][i_b_idx];
  assign o_rd_data = r_mem[i_rd_mat][i_rd_idx];

endmodule

// File: rtl/matrix_op_unit.sv
// Sequential 4x4 matrix unit: one element or one MAC per cycle, with a
// scratch buffer so MMUL/TRANSPOSE may overwrite one of their own operands.
module matrix_op_unit
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [MAT_W-1:0]  cmd_dest,
  input  logic [MAT_W-1:0]  cmd_src,
  input  logic [DATA_W-1:0] scalar_in,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic [MAT_W-1:0]  rd_mat,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              halted
);

  localparam int CNT_W = 3 * ROW_W;

  state_t                         r_state;
  logic [2:0]                     r_op;
  logic [MAT_W-1:0]               r_dest, r_src;
  logic [DATA_W-1:0]              r_scalar, r_acc;
  logic [CNT_W-1:0]               r_cnt;
  logic                           r_done;
  logic [NUM_EL-1:0][DATA_W-1:0]  r_scratch;

  logic [ROW_W-1:0]  w_i, w_j, w_m;
  logic [IDX_W-1:0]  w_k, w_a_idx, w_b_idx;
  logic [DATA_W-1:0] w_a, w_b, w_mul_b, w_prod, w_mac, w_wdata;
  logic              w_we, w_commit;

  // One counter serves all sequences: low bits are k for element ops, {i,j,m} for MMUL.
  assign w_i = r_cnt[3*ROW_W-1:2*ROW_W];
  assign w_j = r_cnt[2*ROW_W-1:ROW_W];
  assign w_m = r_cnt[ROW_W-1:0];
  assign w_k = r_cnt[IDX_W-1:0];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_a_idx = w_k;
    w_b_idx = w_k;
    if (r_state == ST_MMUL) begin
      w_a_idx = idx(w_i, w_m);
      w_b_idx = idx(w_m, w_j);
    end
    w_mul_b = (r_op == OP_SCAL) ? r_scalar : w_b;
    w_prod  = w_a * w_mul_b;
    w_mac   = (w_m == '0) ? w_prod : r_acc + w_prod;
    w_we    = 1'b0;
    w_wdata = '0;
    case (r_state)
      ST_LOAD: begin
        w_we    = load_valid;
        w_wdata = load_data;
      end
      ST_ELEM: begin
        w_we = 1'b1;
        case (r_op)
          OP_ADD:  w_wdata = w_a + w_b;
          OP_SUB:  w_wdata = w_a - w_b;
          default: w_wdata = w_prod;
        endcase
      end
      default: ;
    endcase
  end

  assign w_commit = (r_state == ST_COMMIT);

  matrix_regfile u_regfile (
    .clk       (clk),
    .reset     (reset),
    .i_a_mat   (r_dest),
    .i_a_idx   (w_a_idx),
    .o_a_data  (w_a),
    .i_b_mat   (r_src),
    .i_b_idx   (w_b_idx),
    .o_b_data  (w_b),
    .i_rd_mat  (rd_mat),
    .i_rd_idx  (rd_idx),
    .o_rd_data (rd_data),
    .i_we      (w_we),
    .i_w_mat   (r_dest),
    .i_w_idx   (w_k),
    .i_w_data  (w_wdata),
    .i_commit  (w_commit),
    .i_c_mat   (r_dest),
    .i_c_data  (r_scratch)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_NOP;
      r_dest   <= '0;
      r_src    <= '0;
      r_scalar <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (cmd_valid) begin
          r_op     <= cmd_op;
          r_dest   <= cmd_dest;
          r_src    <= cmd_src;
          r_scalar <= scalar_in;
          r_cnt    <= '0;
          case (cmd_op)
            OP_NOP:                 r_done  <= 1'b1;
            OP_LOAD:                r_state <= ST_LOAD;
            OP_ADD, OP_SUB, OP_SCAL: r_state <= ST_ELEM;
            OP_MMUL:                r_state <= ST_MMUL;
            OP_XPOSE:               r_state <= ST_XPOSE;
            default:                r_state <= ST_HALT;
          endcase
        end
        ST_LOAD: if (load_valid) begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (&w_k) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        ST_ELEM: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (&w_k) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        ST_MMUL: begin
          r_acc <= w_mac;
          r_cnt <= r_cnt + CNT_W'(1);
          if (&r_cnt) r_state <= ST_COMMIT;
        end
        ST_XPOSE: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (&w_k) r_state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b1;
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Scratch holds only in-flight results, so it needs no reset.
  always_ff @(posedge clk) begin
    if (r_state == ST_MMUL && (&w_m))
      r_scratch[idx(w_i, w_j)] <= w_mac;
    else if (r_state == ST_XPOSE)
      r_scratch[idx(w_m, w_j)] <= w_b;
  end

  assign cmd_ready  = (r_state == ST_IDLE);
  assign load_ready = (r_state == ST_LOAD);
  assign busy       = (r_state != ST_IDLE) && (r_state != ST_HALT);
  assign halted     = (r_state == ST_HALT);
  assign done       = r_done;

endmodule
